// File: rtl/bus_breakin.sv
`default_nettype none
// ============================================================================
// Module      : bus_breakin
// Description : Packs a stream of 4-bit nibbles LSB-first into words of
//               NIBBLES nibbles, with flush for partial words.
// Revision    : 1.0 - initial release
// ============================================================================
module bus_breakin #(
    parameter int NIBBLES = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic [3:0]           in_1,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic                 flush,
    output logic [4*NIBBLES-1:0] out_1,
    output logic [2:0]           out_cnt,
    output logic                 out_valid,
    input  logic                 out_ready
);

    localparam int c_W  = 4 * NIBBLES;
    localparam int c_IW = (NIBBLES > 2) ? 2 : 1;

    logic [c_IW-1:0] r_idx;
    logic [c_W-1:0]  r_acc;
    logic [c_W-1:0]  r_out;
    logic [2:0]      r_cnt;
    logic            r_valid;

    logic            w_in_ready;
    logic            w_accept;
    logic            w_last;
    logic            w_emit;
    logic [c_W-1:0]  w_nib_pos;
    logic [c_W-1:0]  w_merged;
    logic [2:0]      w_cnt;

    // The accumulator keeps each nibble at its final bit position, so the
    // emitted word is simply the accumulator with the incoming nibble OR'd in.
    always_comb begin
        w_in_ready = !r_valid || out_ready;
        w_accept   = in_valid && w_in_ready;
        w_nib_pos  = c_W'(in_1) << {r_idx, 2'b00};
        w_merged   = r_acc | (w_accept ? w_nib_pos : '0);
        w_cnt      = 3'(r_idx) + 3'(w_accept);
        w_last     = w_accept && (r_idx == c_IW'(NIBBLES - 1));
        w_emit     = w_last || (flush && w_in_ready && ((r_idx != '0) || w_accept));
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_idx   <= '0;
            r_acc   <= '0;
            r_out   <= '0;
            r_cnt   <= '0;
            r_valid <= 1'b0;
        end else begin
            if (w_emit) begin
                r_out   <= w_merged;
                r_cnt   <= w_cnt;
                r_valid <= 1'b1;
                r_idx   <= '0;
                r_acc   <= '0;
            end else begin
                if (r_valid && out_ready) begin
                    r_valid <= 1'b0;
                end
                if (w_accept) begin
                    r_idx <= r_idx + c_IW'(1);
                    r_acc <= w_merged;
                end
            end
        end
    end

    assign in_ready  = w_in_ready;
    assign out_1     = r_out;
    assign out_cnt   = r_cnt;
    assign out_valid = r_valid;

endmodule
`default_nettype wire

// File: tb/tb_bus_breakin.sv
`default_nettype none
// ============================================================================
// Module      : tb_bus_breakin
// Description : Scoreboard bench for bus_breakin, NIBBLES=2 and NIBBLES=4.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_bus_breakin;

    logic        clk = 1'b0;
    logic        rst_n;

    logic [3:0]  a_in;
    logic        a_iv, a_inr, a_fl, a_ov, a_or;
    logic [7:0]  a_out;
    logic [2:0]  a_cnt;

    logic [3:0]  b_in;
    logic        b_iv, b_inr, b_fl, b_ov, b_or;
    logic [15:0] b_out;
    logic [2:0]  b_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    logic [15:0] qa_w[$];
    logic [2:0]  qa_c[$];
    logic [15:0] qb_w[$];
    logic [2:0]  qb_c[$];

    always #5 clk = ~clk;

    bus_breakin #(.NIBBLES(2)) u_dut_a (
        .clk(clk), .rst_n(rst_n), .in_1(a_in), .in_valid(a_iv), .in_ready(a_inr),
        .flush(a_fl), .out_1(a_out), .out_cnt(a_cnt), .out_valid(a_ov), .out_ready(a_or)
    );

    bus_breakin #(.NIBBLES(4)) u_dut_b (
        .clk(clk), .rst_n(rst_n), .in_1(b_in), .in_valid(b_iv), .in_ready(b_inr),
        .flush(b_fl), .out_1(b_out), .out_cnt(b_cnt), .out_valid(b_ov), .out_ready(b_or)
    );

    task automatic chk(input string name, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_ready_a(input string name, input int exp);
        #1;
        chk(name, int'(a_inr), exp);
    endtask

    // Monitors: a take happens at the next rising edge whenever valid&&ready
    // is seen here, since inputs only change just after rising edges.
    always @(negedge clk) begin
        if (rst_n && a_ov && a_or) begin
            if (qa_w.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_a_unexpected: got word 0x%0h cnt %0d, expected no word", a_out, a_cnt);
            end else begin
                chk("mon_a_word", int'(a_out), int'(qa_w.pop_front()));
                chk("mon_a_cnt", int'(a_cnt), int'(qa_c.pop_front()));
            end
        end
    end

    always @(negedge clk) begin
        if (rst_n && b_ov && b_or) begin
            if (qb_w.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL mon_b_unexpected: got word 0x%0h cnt %0d, expected no word", b_out, b_cnt);
            end else begin
                chk("mon_b_word", int'(b_out), int'(qb_w.pop_front()));
                chk("mon_b_cnt", int'(b_cnt), int'(qb_c.pop_front()));
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout, expected test completion");
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        a_in = 4'h0; a_iv = 1'b0; a_fl = 1'b0; a_or = 1'b1;
        b_in = 4'h0; b_iv = 1'b0; b_fl = 1'b0; b_or = 1'b1;
        a_in = 4'hF; a_iv = 1'b1; a_fl = 1'b1;
        cyc(); cyc();
        a_iv = 1'b0; a_fl = 1'b0;
        chk("rst_a_valid", int'(a_ov), 0);
        chk("rst_a_out", int'(a_out), 0);
        chk("rst_a_cnt", int'(a_cnt), 0);
        chk("rst_b_valid", int'(b_ov), 0);
        chk("rst_b_out", int'(b_out), 0);
        rst_n = 1'b1;
        chk_ready_a("rst_in_ready", 1);
        cyc();

        // Test A
        a_in = 4'h3; a_iv = 1'b1; cyc();
        a_in = 4'hA; qa_w.push_back(16'h00A3); qa_c.push_back(3'd2); cyc();
        a_iv = 1'b0;
        chk("A_valid", int'(a_ov), 1);
        chk("A_word", int'(a_out), 'hA3);
        chk("A_cnt", int'(a_cnt), 2);
        cyc();
        chk("A_drained", int'(a_ov), 0);

        // Test B
        for (int i = 1; i <= 6; i++) begin
            a_in = 4'(i); a_iv = 1'b1;
            if ((i % 2) == 0) begin
                qa_w.push_back(16'((i << 4) | (i - 1)));
                qa_c.push_back(3'd2);
            end
            chk_ready_a("B_in_ready", 1);
            cyc();
        end
        a_iv = 1'b0;
        cyc(); cyc();

        // Test C
        a_or = 1'b0;
        a_in = 4'h1; a_iv = 1'b1; cyc();
        a_in = 4'h2; cyc();
        chk("C_loaded", int'(a_ov), 1);
        a_in = 4'h3;
        chk_ready_a("C_blocked", 0);
        for (int i = 0; i < 3; i++) begin
            cyc();
            chk("C_hold_word", int'(a_out), 'h21);
            chk_ready_a("C_blocked_hold", 0);
        end
        a_or = 1'b1;
        qa_w.push_back(16'h0021); qa_c.push_back(3'd2);
        chk_ready_a("C_released", 1);
        cyc();
        a_iv = 1'b0;
        chk("C_taken_once", int'(a_ov), 0);
        qa_w.push_back(16'h0003); qa_c.push_back(3'd1);
        a_fl = 1'b1; cyc();
        a_fl = 1'b0;
        chk("C_flush_cnt", int'(a_cnt), 1);
        cyc();

        // Test D
        a_in = 4'h7; a_iv = 1'b1; cyc();
        a_iv = 1'b0; a_fl = 1'b1;
        qa_w.push_back(16'h0007); qa_c.push_back(3'd1); cyc();
        a_fl = 1'b0;
        chk("D_flush_word", int'(a_out), 'h07);
        chk("D_flush_cnt", int'(a_cnt), 1);
        cyc();
        a_in = 4'h5; a_iv = 1'b1; a_fl = 1'b1;
        qa_w.push_back(16'h0005); qa_c.push_back(3'd1); cyc();
        a_iv = 1'b0; a_fl = 1'b0;
        chk("D_flush_accept_word", int'(a_out), 'h05);
        chk("D_flush_accept_cnt", int'(a_cnt), 1);
        cyc();
        a_fl = 1'b1; cyc();
        a_fl = 1'b0;
        chk("D_empty_flush", int'(a_ov), 0);
        cyc();
        chk("D_empty_flush_later", int'(a_ov), 0);
        a_in = 4'h8; a_iv = 1'b1; cyc();
        a_in = 4'h9; a_fl = 1'b1;
        qa_w.push_back(16'h0098); qa_c.push_back(3'd2); cyc();
        a_iv = 1'b0; a_fl = 1'b0;
        chk("D_flush_full_cnt", int'(a_cnt), 2);
        cyc();
        chk("D_no_extra_word", int'(a_ov), 0);

        // Test E
        a_in = 4'h9; a_iv = 1'b1; cyc();
        a_iv = 1'b0; rst_n = 1'b0; cyc();
        chk("E_rst_valid", int'(a_ov), 0);
        chk("E_rst_word", int'(a_out), 0);
        chk("E_rst_cnt", int'(a_cnt), 0);
        rst_n = 1'b1;
        a_in = 4'h1; a_iv = 1'b1; cyc();
        a_in = 4'h2; qa_w.push_back(16'h0021); qa_c.push_back(3'd2); cyc();
        a_iv = 1'b0;
        chk("E_word", int'(a_out), 'h21);
        cyc();

        // Test F
        for (int i = 1; i <= 4; i++) begin
            b_in = 4'(i); b_iv = 1'b1;
            if (i == 4) begin
                qb_w.push_back(16'h4321); qb_c.push_back(3'd4);
            end
            cyc();
        end
        b_iv = 1'b0;
        chk("F_valid", int'(b_ov), 1);
        chk("F_word", int'(b_out), 'h4321);
        chk("F_cnt", int'(b_cnt), 4);
        b_in = 4'h5; b_iv = 1'b1; cyc();
        b_in = 4'h6; b_fl = 1'b1;
        qb_w.push_back(16'h0065); qb_c.push_back(3'd2); cyc();
        b_iv = 1'b0; b_fl = 1'b0;
        chk("F_partial_word", int'(b_out), 'h0065);
        cyc(); cyc(); cyc();

        chk("end_queue_a_empty", qa_w.size(), 0);
        chk("end_queue_b_empty", qb_w.size(), 0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
